// File: rtl/tile_renderer_pkg.sv
// Shared definitions for the tile renderer: tile codes, RGB444 palette,
// grid geometry and a small range helper used by both pipeline stages.
//
// Contents:
//   tile_e       - map tile codes returned by the game logic
//   TILE_SHIFT   - log2 of the tile edge length in pixels (32 px tiles)
//   GRID_N       - tiles per grid side
//   C_*          - 12-bit {R,G,B} colour constants
//   inRange()    - inclusive range test on a 5-bit in-tile coordinate
package tile_renderer_pkg;

  typedef enum logic [3:0] {
    T_FLOOR    = 4'd0,
    T_WALL     = 4'd1,
    T_BOX      = 4'd2,
    T_BOX_GOAL = 4'd3,
    T_GOAL     = 4'd4
  } tile_e;

  localparam int TILE_SHIFT = 5;
  localparam int GRID_N     = 8;

  localparam logic [11:0] C_BLACK   = 12'h000;
  localparam logic [11:0] C_WIN     = 12'h0F0;
  localparam logic [11:0] C_PLAYER  = 12'hF80;
  localparam logic [11:0] C_FLOOR   = 12'h222;
  localparam logic [11:0] C_MORTAR  = 12'h888;
  localparam logic [11:0] C_BRICK   = 12'hA40;
  localparam logic [11:0] C_BOXEDGE = 12'h630;
  localparam logic [11:0] C_BOXFILL = 12'hC83;
  localparam logic [11:0] C_BOXGOAL = 12'h0C4;
  localparam logic [11:0] C_GOAL    = 12'hFF0;
  localparam logic [11:0] C_ERROR   = 12'hF0F;

  function automatic logic inRange(input logic [4:0] v,
                                   input logic [4:0] lo,
                                   input logic [4:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/tile_renderer_painter.sv
// Combinational tile painter: turns a tile code plus the pixel position
// inside the 32x32 tile into an RGB444 colour.
//
// Ports:
//   i_tile      - tile code from the map
//   i_lx, i_ly  - pixel position inside the tile, 0..31
//   i_isPlayer  - pixel lies in the player sprite square of the player tile
//   i_blinkOff  - player is in the dark half of its win blink
//   o_rgb       - {R,G,B} colour for this pixel
module tile_renderer_painter
  import tile_renderer_pkg::*;
(
  input  logic [3:0]  i_tile,
  input  logic [4:0]  i_lx,
  input  logic [4:0]  i_ly,
  input  logic        i_isPlayer,
  input  logic        i_blinkOff,
  output logic [11:0] o_rgb
);

  logic w_mortar;
  logic w_boxEdge;
  logic w_goalCore;

  // Mortar lines every 16 px give two brick courses per tile.
  assign w_mortar = (i_lx[3:0] == 4'h0) || (i_ly[3:0] == 4'h0);

  // Box border is two pixels thick: in-tile coordinates 0,1 and 30,31.
  assign w_boxEdge = (i_lx[4:1] == 4'h0) || (i_lx[4:1] == 4'hF) ||
                     (i_ly[4:1] == 4'h0) || (i_ly[4:1] == 4'hF);

  assign w_goalCore = inRange(i_lx, 5'd12, 5'd19) && inRange(i_ly, 5'd12, 5'd19);

  // The player sprite is painted over whatever tile it stands on; unknown
  // tile codes fall through to magenta so map corruption is visible.
  always_comb begin
    o_rgb = C_ERROR;
    if (i_isPlayer) begin
      o_rgb = i_blinkOff ? C_FLOOR : C_PLAYER;
    end else begin
      case (i_tile)
        T_FLOOR:    o_rgb = C_FLOOR;
        T_WALL:     o_rgb = w_mortar ? C_MORTAR : C_BRICK;
        T_BOX:      o_rgb = w_boxEdge ? C_BOXEDGE : C_BOXFILL;
        T_BOX_GOAL: o_rgb = w_boxEdge ? C_BOXEDGE : C_BOXGOAL;
        T_GOAL:     o_rgb = w_goalCore ? C_GOAL : C_FLOOR;
        default:    o_rgb = C_ERROR;
      endcase
    end
  end

endmodule

// File: rtl/tile_renderer.sv
// Pixel-colour stage between the game map and the VGA controller.
// Stage 1 registers the tile address and in-tile position of the scan pixel;
// stage 2 paints the returned tile into pix_rgb. Address-to-colour latency
// is two clocks. A vs-driven frame counter times the player blink and the
// win flash around the grid.
//
// Ports:
//   i_clk        - pixel clock
//   i_rst        - asynchronous active-high reset
//   i_row_addr   - scan row 0..479
//   i_col_addr   - scan column 0..639
//   i_rdn        - active-low display enable
//   i_vs         - vertical sync
//   o_map_x/y    - registered tile column/row presented to the game logic
//   i_map_tile   - tile at (map_x, map_y), returned combinationally
//   i_p_x/i_p_y  - player tile coordinates
//   i_win        - level-complete flag
//   o_pix_rgb    - {R,G,B} colour to the VGA controller
module tile_renderer
  import tile_renderer_pkg::*;
#(
  parameter int X0        = 192,
  parameter int Y0        = 112,
  parameter int BLINK_BIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [8:0]  i_row_addr,
  input  logic [9:0]  i_col_addr,
  input  logic        i_rdn,
  input  logic        i_vs,
  output logic [2:0]  o_map_x,
  output logic [2:0]  o_map_y,
  input  logic [3:0]  i_map_tile,
  input  logic [2:0]  i_p_x,
  input  logic [2:0]  i_p_y,
  input  logic        i_win,
  output logic [11:0] o_pix_rgb
);

  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic        w_inGrid;
  logic        r_de;
  logic        r_inGrid;
  logic [4:0]  r_lx;
  logic [4:0]  r_ly;
  logic        r_vsQ;
  logic [7:0]  r_frameCnt;
  logic        w_isPlayer;
  logic        w_blinkOff;
  logic [11:0] w_tileRgb;
  logic [11:0] w_nextRgb;

  // Offsets wrap modulo 1024, so pixels left of / above the grid become
  // large values and a single unsigned compare covers both sides.
  assign w_dx     = i_col_addr - 10'(X0);
  assign w_dy     = {1'b0, i_row_addr} - 10'(Y0);
  assign w_inGrid = (w_dx[9:8] == 2'b00) && (w_dy[9:8] == 2'b00);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_de     <= 1'b0;
      r_inGrid <= 1'b0;
      o_map_x  <= 3'd0;
      o_map_y  <= 3'd0;
      r_lx     <= 5'd0;
      r_ly     <= 5'd0;
    end else begin
      r_de     <= ~i_rdn;
      r_inGrid <= w_inGrid;
      o_map_x  <= w_dx[7:TILE_SHIFT];
      o_map_y  <= w_dy[7:TILE_SHIFT];
      r_lx     <= w_dx[TILE_SHIFT-1:0];
      r_ly     <= w_dy[TILE_SHIFT-1:0];
    end
  end

  // Frame counter advances once per rising edge of vs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vsQ      <= 1'b0;
      r_frameCnt <= 8'd0;
    end else begin
      r_vsQ <= i_vs;
      if (i_vs && !r_vsQ) begin
        r_frameCnt <= r_frameCnt + 8'd1;
      end
    end
  end

  // The sprite is the central 16x16 square of the player's tile.
  assign w_isPlayer = (o_map_x == i_p_x) && (o_map_y == i_p_y) &&
                      inRange(r_lx, 5'd8, 5'd23) && inRange(r_ly, 5'd8, 5'd23);
  assign w_blinkOff = i_win && !r_frameCnt[BLINK_BIT];

  tile_renderer_painter u_painter (
    .i_tile     (i_map_tile),
    .i_lx       (r_lx),
    .i_ly       (r_ly),
    .i_isPlayer (w_isPlayer),
    .i_blinkOff (w_blinkOff),
    .o_rgb      (w_tileRgb)
  );

  // Blanking wins over everything; the win flash only lights the border
  // area so the solved board stays readable.
  always_comb begin
    w_nextRgb = C_BLACK;
    if (!r_de) begin
      w_nextRgb = C_BLACK;
    end else if (!r_inGrid && i_win && r_frameCnt[BLINK_BIT]) begin
      w_nextRgb = C_WIN;
    end else if (!r_inGrid) begin
      w_nextRgb = C_BLACK;
    end else begin
      w_nextRgb = w_tileRgb;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pix_rgb <= C_BLACK;
    end else begin
      o_pix_rgb <= w_nextRgb;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: the driver pushes hand-computed
// expectations tagged with the cycle they become due, and a monitor pops
// and compares them one ns after each rising clock edge.
module tb_tile_renderer;

  logic        clk;
  logic        rst;
  logic [8:0]  rowAddr;
  logic [9:0]  colAddr;
  logic        rdn;
  logic        vs;
  logic [2:0]  mapX;
  logic [2:0]  mapY;
  logic [3:0]  mapTile;
  logic [2:0]  pX;
  logic [2:0]  pY;
  logic        win;
  logic [11:0] pixRgb;

  typedef struct {
    logic [11:0] rgb;
    logic [2:0]  mx;
    logic [2:0]  my;
    bit          chkMap;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   assertions = 0;
  int   failures = 0;

  tile_renderer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_row_addr (rowAddr),
    .i_col_addr (colAddr),
    .i_rdn      (rdn),
    .i_vs       (vs),
    .o_map_x    (mapX),
    .o_map_y    (mapY),
    .i_map_tile (mapTile),
    .i_p_x      (pX),
    .i_p_y      (pY),
    .i_win      (win),
    .o_pix_rgb  (pixRgb)
  );

  // 10 ns pixel clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [11:0] actRgb,
                             input logic [11:0] expRgb, input bit chkMap,
                             input logic [2:0] actX, input logic [2:0] expX,
                             input logic [2:0] actY, input logic [2:0] expY);
    assertions++;
    if ((actRgb !== expRgb) || (chkMap && ((actX !== expX) || (actY !== expY)))) begin
      failures++;
      $display("[TB] FAIL %s: got rgb=%h map=(%0d,%0d), expected rgb=%h map=(%0d,%0d)",
               name, actRgb, actX, actY, expRgb, expX, expY);
    end
  endtask

  // Holds one scan position for three clocks so the expectation is stable
  // when it comes due two edges after the drive.
  task automatic applyStimulus(input int col, input int row, input logic rdnV,
                               input logic [3:0] tile, input logic [11:0] expRgb,
                               input bit chkMap, input logic [2:0] ex,
                               input logic [2:0] ey, input string name);
    exp_t item;
    @(negedge clk);
    colAddr = 10'(col);
    rowAddr = 9'(row);
    rdn     = rdnV;
    mapTile = tile;
    item.rgb    = expRgb;
    item.mx     = ex;
    item.my     = ey;
    item.chkMap = chkMap;
    item.due    = cycle + 2;
    item.name   = name;
    sb.push_back(item);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulseVs(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vs = 1'b1;
      repeat (2) @(negedge clk);
      vs = 1'b0;
      @(negedge clk);
    end
  endtask

  // Monitor: compares every expectation that has come due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      while (sb.size() > 0 && sb[0].due <= cycle) begin
        e = sb.pop_front();
        checkOutput(e.name, pixRgb, e.rgb, e.chkMap, mapX, e.mx, mapY, e.my);
      end
    end
  end

  // Watchdog in case the clock or a wait stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rowAddr = '0; colAddr = '0; rdn = 1'b1; vs = 1'b0;
    mapTile = '0; pX = 3'd7; pY = 3'd7; win = 1'b0;
    #3;
    checkOutput("reset_state", pixRgb, 12'h000, 1'b1, mapX, 3'd0, mapY, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Wall: brick body vs mortar line
    applyStimulus(200, 120, 1'b0, 4'd1, 12'hA40, 1'b1, 3'd0, 3'd0, "wall_brick_lx8");
    applyStimulus(208, 120, 1'b0, 4'd1, 12'h888, 1'b1, 3'd0, 3'd0, "wall_mortar_lx16");

    // Grid boundaries
    applyStimulus(191, 200, 1'b0, 4'd0, 12'h000, 1'b0, 3'd0, 3'd0, "col191_outside");
    applyStimulus(192, 200, 1'b0, 4'd0, 12'h222, 1'b1, 3'd0, 3'd2, "col192_inside");
    applyStimulus(447, 200, 1'b0, 4'd0, 12'h222, 1'b1, 3'd7, 3'd2, "col447_inside");
    applyStimulus(448, 200, 1'b0, 4'd0, 12'h000, 1'b0, 3'd0, 3'd0, "col448_outside");
    applyStimulus(300, 111, 1'b0, 4'd0, 12'h000, 1'b0, 3'd0, 3'd0, "row111_outside");
    applyStimulus(300, 112, 1'b0, 4'd0, 12'h222, 1'b1, 3'd3, 3'd0, "row112_inside");
    applyStimulus(300, 367, 1'b0, 4'd0, 12'h222, 1'b1, 3'd3, 3'd7, "row367_inside");
    applyStimulus(300, 368, 1'b0, 4'd0, 12'h000, 1'b0, 3'd0, 3'd0, "row368_outside");

    // Player sprite at tile (3,2) and its left margin
    pX = 3'd3; pY = 3'd2;
    applyStimulus(298, 186, 1'b0, 4'd0, 12'hF80, 1'b1, 3'd3, 3'd2, "player_center");
    applyStimulus(293, 186, 1'b0, 4'd1, 12'hA40, 1'b1, 3'd3, 3'd2, "player_margin_lx5");

    // Box, box-on-goal, goal
    applyStimulus(224, 130, 1'b0, 4'd2, 12'h630, 1'b1, 3'd1, 3'd0, "box_edge");
    applyStimulus(240, 130, 1'b0, 4'd2, 12'hC83, 1'b1, 3'd1, 3'd0, "box_fill");
    applyStimulus(240, 130, 1'b0, 4'd3, 12'h0C4, 1'b1, 3'd1, 3'd0, "boxgoal_fill");
    applyStimulus(255, 130, 1'b0, 4'd3, 12'h630, 1'b1, 3'd1, 3'd0, "boxgoal_edge_lx31");
    applyStimulus(271, 127, 1'b0, 4'd4, 12'hFF0, 1'b1, 3'd2, 3'd0, "goal_core");
    applyStimulus(276, 127, 1'b0, 4'd4, 12'h222, 1'b1, 3'd2, 3'd0, "goal_outer");

    // Error tiles and blanking
    applyStimulus(250, 200, 1'b0, 4'd7, 12'hF0F, 1'b1, 3'd1, 3'd2, "tile7_error");
    applyStimulus(250, 200, 1'b0, 4'd15, 12'hF0F, 1'b1, 3'd1, 3'd2, "tile15_error");
    applyStimulus(250, 200, 1'b1, 4'd1, 12'h000, 1'b1, 3'd1, 3'd2, "rdn_high");

    // Advance frame counter, then reset mid-line must clear it and blank at once
    pulseVs(20);
    pX = 3'd7; pY = 3'd7;
    applyStimulus(298, 186, 1'b0, 4'd1, 12'hA40, 1'b1, 3'd3, 3'd2, "pre_reset_pixel");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_async", pixRgb, 12'h000, 1'b1, mapX, 3'd0, mapY, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(298, 186, 1'b0, 4'd1, 12'hA40, 1'b1, 3'd3, 3'd2, "post_reset_resume");

    // Win flash and player blink; frame_cnt starts from 0 after the reset
    win = 1'b1; pX = 3'd3; pY = 3'd2;
    pulseVs(16);
    applyStimulus(10, 10, 1'b0, 4'd0, 12'h0F0, 1'b0, 3'd0, 3'd0, "win_flash_on");
    applyStimulus(298, 186, 1'b0, 4'd0, 12'hF80, 1'b1, 3'd3, 3'd2, "win_player_lit");
    pulseVs(16);
    applyStimulus(10, 10, 1'b0, 4'd0, 12'h000, 1'b0, 3'd0, 3'd0, "win_flash_off");
    applyStimulus(298, 186, 1'b0, 4'd1, 12'h222, 1'b1, 3'd3, 3'd2, "win_player_dark");
    applyStimulus(10, 10, 1'b1, 4'd0, 12'h000, 1'b0, 3'd0, 3'd0, "win_rdn_blank");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
